// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter with valid/ready word intake and a last-bit marker.
// Optional even-parity bit per frame when PISO_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             busy
);

`ifdef PISO_PARITY_EN
    localparam int FLEN = WIDTH + 1;
`else
    localparam int FLEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FLEN  = CW'(FLEN);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_nxt_s;
    logic             sout_r;
    logic             sout_nxt_s;
    logic             sout_valid_r;
    logic             sout_valid_nxt_s;
    logic             last_r;
    logic             last_nxt_s;
    logic             din_ready_s;
    logic             handshake_s;
`ifdef PISO_PARITY_EN
    localparam logic [CW-1:0] CNT_WIDTH = CW'(WIDTH);
    logic             par_r;
    logic             par_nxt_s;
`endif

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    // Moves the next bit to send into the position first_bit() reads.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

`ifdef PISO_PARITY_EN
    function automatic logic even_parity(input logic [WIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    assign din_ready_s = (state_r == IDLE) | ((state_r == SHIFT) & last_r);
    assign handshake_s = din_valid & din_ready_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a word accepted on the last bit keeps us in SHIFT with no gap.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (handshake_s) begin
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (last_r && !handshake_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output/datapath next values; the counter holds the 1-based index of the bit on sout.
    always_comb begin
        cnt_nxt_s        = CNT_ZERO;
        shreg_nxt_s      = shreg_r;
        sout_nxt_s       = 1'b0;
        sout_valid_nxt_s = 1'b0;
        last_nxt_s       = 1'b0;
`ifdef PISO_PARITY_EN
        par_nxt_s        = par_r;
`endif
        if (handshake_s) begin
            cnt_nxt_s        = CNT_ONE;
            shreg_nxt_s      = shift_word(din);
            sout_nxt_s       = first_bit(din);
            sout_valid_nxt_s = 1'b1;
            last_nxt_s       = (CNT_ONE == CNT_FLEN);
`ifdef PISO_PARITY_EN
            par_nxt_s        = even_parity(din);
`endif
        end else if ((state_r == SHIFT) && !last_r) begin
            cnt_nxt_s        = cnt_r + CNT_ONE;
            sout_valid_nxt_s = 1'b1;
            last_nxt_s       = ((cnt_r + CNT_ONE) == CNT_FLEN);
`ifdef PISO_PARITY_EN
            if (cnt_r < CNT_WIDTH) begin
                sout_nxt_s  = first_bit(shreg_r);
                shreg_nxt_s = shift_word(shreg_r);
            end else begin
                sout_nxt_s  = par_r;
            end
`else
            sout_nxt_s       = first_bit(shreg_r);
            shreg_nxt_s      = shift_word(shreg_r);
`endif
        end else begin
            shreg_nxt_s      = shreg_r;
        end
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r        <= CNT_ZERO;
            shreg_r      <= {WIDTH{1'b0}};
            sout_r       <= 1'b0;
            sout_valid_r <= 1'b0;
            last_r       <= 1'b0;
`ifdef PISO_PARITY_EN
            par_r        <= 1'b0;
`endif
        end else begin
            cnt_r        <= cnt_nxt_s;
            shreg_r      <= shreg_nxt_s;
            sout_r       <= sout_nxt_s;
            sout_valid_r <= sout_valid_nxt_s;
            last_r       <= last_nxt_s;
`ifdef PISO_PARITY_EN
            par_r        <= par_nxt_s;
`endif
        end
    end

    assign din_ready  = din_ready_s;
    assign sout       = sout_r;
    assign sout_valid = sout_valid_r;
    assign last       = last_r;
    assign busy       = sout_valid_r;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: MSB-first and LSB-first instances share stimulus,
// expected frames come from a bit-index model (plus parity bit when PISO_PARITY_EN is defined).
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FLEN = W + 1;
`else
    localparam int FLEN = W;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready, sout, sout_valid, last, busy;
    logic         din_ready_l, sout_l, sout_valid_l, last_l, busy_l;

    int           pass_cnt  = 0;
    int           total_cnt = 0;
    logic [W-1:0] wq[$];

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .sout(sout), .sout_valid(sout_valid), .last(last), .busy(busy)
    );

    piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_l),
        .sout(sout_l), .sout_valid(sout_valid_l), .last(last_l), .busy(busy_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit k (0-based) of the frame for word w; index W is the even-parity bit.
    function automatic logic exp_bit(input logic [W-1:0] w, input int k, input bit msb);
        if (k >= W) return ^w;
        else if (msb) return w[W-1-k];
        else return w[k];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sends every word of wq back to back and checks each frame bit plus the idle cycle after.
    task automatic run_frames(input string tag, input bit hold_valid, input bit noisy);
        logic [W-1:0] cur;
        logic [4:0]   got;
        logic [4:0]   exp_v;
        din       = wq[0];
        din_valid = 1'b1;
        step();
        for (int i = 0; i < wq.size(); i++) begin
            cur = wq[i];
            for (int k = 0; k < FLEN; k++) begin
                if (k == FLEN - 1) begin
                    if (i + 1 < wq.size()) begin
                        din       = wq[i+1];
                        din_valid = 1'b1;
                    end else begin
                        din       = W'($urandom);
                        din_valid = 1'b0;
                    end
                end else if (noisy) begin
                    din       = k[0] ? 4'b0000 : W'($urandom);
                    din_valid = 1'b1;
                end else if (hold_valid && (i + 1 < wq.size())) begin
                    din       = wq[i+1];
                    din_valid = 1'b1;
                end else begin
                    din_valid = 1'b0;
                end
                @(negedge clk);
                exp_v = {exp_bit(cur, k, 1'b1), 1'b1, (k == FLEN - 1), 1'b1, (k == FLEN - 1)};
                got   = {sout, sout_valid, last, busy, din_ready};
                total_cnt++;
                if (got !== exp_v)
                    $display("FAIL %s_msb word%0d=%b bit%0d: {sout,valid,last,busy,ready}=%b expected %b",
                             tag, i, cur, k, got, exp_v);
                else pass_cnt++;
                exp_v = {exp_bit(cur, k, 1'b0), 1'b1, (k == FLEN - 1), 1'b1, (k == FLEN - 1)};
                got   = {sout_l, sout_valid_l, last_l, busy_l, din_ready_l};
                total_cnt++;
                if (got !== exp_v)
                    $display("FAIL %s_lsb word%0d=%b bit%0d: {sout,valid,last,busy,ready}=%b expected %b",
                             tag, i, cur, k, got, exp_v);
                else pass_cnt++;
                step();
            end
        end
        @(negedge clk);
        got = {sout, sout_valid, last, busy, din_ready};
        total_cnt++;
        if (got !== 5'b00001)
            $display("FAIL %s_idle_msb: {sout,valid,last,busy,ready}=%b expected 00001", tag, got);
        else pass_cnt++;
        got = {sout_l, sout_valid_l, last_l, busy_l, din_ready_l};
        total_cnt++;
        if (got !== 5'b00001)
            $display("FAIL %s_idle_lsb: {sout,valid,last,busy,ready}=%b expected 00001", tag, got);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst       = 1'b1;
        din       = 4'b1011;
        din_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            @(negedge clk);
            got = {sout, sout_valid, last, busy, din_ready,
                   sout_l, sout_valid_l, last_l, busy_l, din_ready_l};
            total_cnt++;
            if (got !== 10'b00001_00001)
                $display("FAIL reset_cycle%0d: outputs=%b expected 0000100001", c, got);
            else pass_cnt++;
        end
        rst       = 1'b0;
        din_valid = 1'b0;
        step();
        @(negedge clk);
        got = {sout, sout_valid, last, busy, din_ready,
               sout_l, sout_valid_l, last_l, busy_l, din_ready_l};
        total_cnt++;
        if (got !== 10'b00001_00001)
            $display("FAIL reset_no_accept: outputs=%b expected 0000100001", got);
        else pass_cnt++;
    endtask

    task automatic test_single();
        wq = '{4'b1011};
        run_frames("single_1011", 1'b0, 1'b0);
        for (int n = 0; n < 4; n++) begin
            wq = '{W'($urandom)};
            run_frames("single_rand", 1'b0, 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        wq = '{4'b1011, 4'b0110};
        run_frames("b2b_fixed", 1'b1, 1'b0);
        wq = {};
        for (int n = 0; n < 5; n++) wq.push_back(W'($urandom));
        run_frames("b2b_rand", 1'b1, 1'b0);
    endtask

    task automatic test_held_off();
        wq = '{4'b1011, W'($urandom), W'($urandom)};
        run_frames("held_off", 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_frame();
        logic [4:0] got;
        logic [4:0] exp_v;
        din       = 4'b1011;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp_v = {exp_bit(4'b1011, k, 1'b1), 1'b1, 1'b0, 1'b1, 1'b0};
            got   = {sout, sout_valid, last, busy, din_ready};
            total_cnt++;
            if (got !== exp_v)
                $display("FAIL midrst_pre bit%0d: {sout,valid,last,busy,ready}=%b expected %b", k, got, exp_v);
            else pass_cnt++;
            step();
        end
        rst       = 1'b1;
        din       = 4'b1111;
        din_valid = 1'b1;
        step();
        @(negedge clk);
        got = {sout, sout_valid, last, busy, din_ready};
        total_cnt++;
        if (got !== 5'b00001)
            $display("FAIL midrst_cleared: {sout,valid,last,busy,ready}=%b expected 00001", got);
        else pass_cnt++;
        rst       = 1'b0;
        din_valid = 1'b0;
        step();
        @(negedge clk);
        got = {sout, sout_valid, last, busy, din_ready};
        total_cnt++;
        if (got !== 5'b00001)
            $display("FAIL midrst_no_accept: {sout,valid,last,busy,ready}=%b expected 00001", got);
        else pass_cnt++;
        wq = '{4'b0101};
        run_frames("after_rst", 1'b0, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        din       = {W{1'b0}};
        din_valid = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_held_off();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
